// File: rtl/cache_fill_if.sv
// Miss/fill bus between the pipeline-side environment (master) and cache_fill_fsm (slave).
interface cache_fill_if #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
) ();
    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              memory_data_valid;
    logic [DATA_W-1:0] memory_data;
    logic              fsm_busy;
    logic              memory_read_en;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic [IDX_W-1:0]  fill_word_index;
    logic [DATA_W-1:0] fill_data;
    logic              write_tag_array;
    logic [ADDR_W-1:0] fill_block_addr;

    modport master (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, memory_read_en, memory_address, write_data_array,
               fill_word_index, fill_data, write_tag_array, fill_block_addr
    );

    modport slave (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, memory_read_en, memory_address, write_data_array,
               fill_word_index, fill_data, write_tag_array, fill_block_addr
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill: streams block reads to main memory, writes returned words, then the tag.
// Optional FILL_PERF_CNT_EN adds saturating miss_count / fill_cycles outputs.
module cache_fill_fsm #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int OFFSET_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    cache_fill_if.slave        bus
`ifdef FILL_PERF_CNT_EN
    ,
    output logic [15:0]        miss_count,
    output logic [15:0]        fill_cycles
`endif
);
    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam logic [IDX_W:0]    ISSUE_MAX = (IDX_W+1)'(WORDS_PER_BLOCK);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_W-1:0] WORD_B    = ADDR_W'(DATA_W / 8);
    localparam logic [ADDR_W-1:0] OFS_MASK  = ADDR_W'((1 << OFFSET_W) - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic [IDX_W:0]    issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]  recv_cnt_q, recv_cnt_d;
    logic [ADDR_W-1:0] fba_q, fba_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            fba_q       <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            fba_q       <= fba_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        issue_cnt_d          = issue_cnt_q;
        recv_cnt_d           = recv_cnt_q;
        fba_d                = fba_q;
        bus.fsm_busy         = 1'b0;
        bus.memory_read_en   = 1'b0;
        bus.memory_address   = '0;
        bus.write_data_array = 1'b0;
        bus.fill_word_index  = '0;
        bus.fill_data        = '0;
        bus.write_tag_array  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.miss_detected) begin
                    fba_d       = bus.miss_address & ~OFS_MASK;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                bus.fsm_busy = 1'b1;
                if (issue_cnt_q < ISSUE_MAX) begin
                    bus.memory_read_en = 1'b1;
                    bus.memory_address = fba_q + ADDR_W'(issue_cnt_q) * WORD_B;
                    issue_cnt_d        = issue_cnt_q + 1'b1;
                end
                // Returns arrive in issue order, so recv_cnt alone names the slot.
                if (bus.memory_data_valid) begin
                    bus.write_data_array = 1'b1;
                    bus.fill_word_index  = recv_cnt_q;
                    bus.fill_data        = bus.memory_data;
                    if (recv_cnt_q == LAST_IDX) begin
                        bus.write_tag_array = 1'b1;
                        state_d             = IDLE;
                    end else begin
                        recv_cnt_d = recv_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.fill_block_addr = fba_q;

`ifdef FILL_PERF_CNT_EN
    logic [15:0] miss_count_q, fill_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_count_q  <= '0;
            fill_cycles_q <= '0;
        end else begin
            if (state_q == IDLE && bus.miss_detected && miss_count_q != 16'hFFFF)
                miss_count_q <= miss_count_q + 16'd1;
            if (state_q == FILL && fill_cycles_q != 16'hFFFF)
                fill_cycles_q <= fill_cycles_q + 16'd1;
        end
    end

    assign miss_count  = miss_count_q;
    assign fill_cycles = fill_cycles_q;
`endif
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: per-cycle expectations from a timeline model of a fill.
module tb_cache_fill_fsm;
    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    cache_fill_if #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8)) bus ();

`ifdef FILL_PERF_CNT_EN
    logic [15:0] miss_count, fill_cycles;
    cache_fill_fsm #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8), .OFFSET_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .miss_count(miss_count), .fill_cycles(fill_cycles));
`else
    cache_fill_fsm #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8), .OFFSET_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    logic [15:0] last_base;

    function automatic logic [54:0] observe(input logic wr_exp);
        logic [2:0]  idx;
        logic [15:0] dat;
        idx = wr_exp ? bus.fill_word_index : 3'd0;
        dat = wr_exp ? bus.fill_data : 16'd0;
        return {bus.fsm_busy, bus.memory_read_en, bus.memory_address, bus.write_data_array,
                idx, dat, bus.write_tag_array, bus.fill_block_addr};
    endfunction

    task automatic idle_inputs();
        bus.miss_detected = 1'b0;
        bus.miss_address = '0;
        bus.memory_data_valid = 1'b0;
        bus.memory_data = '0;
    endtask

    task automatic test_reset();
        logic [54:0] obs;
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        obs = observe(1'b1);
        n_total++;
        if (obs !== 55'd0) $display("FAIL reset_outputs got=%h want=0", obs);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        last_base = 16'h0000;
    endtask

    // One fill: miss at addr, memory answers each read exactly lat cycles after issue.
    task automatic run_fill(input logic [15:0] addr, input int lat, input logic hold_miss);
        logic [15:0] base;
        logic [54:0] obs, exp;
        int          beat;
        logic        in_fill, rd, wr;
        base = addr & 16'hFFF0;
        @(negedge clk);
        bus.miss_detected = 1'b1;
        bus.miss_address = addr;
        bus.memory_data_valid = 1'b0;
        #1;
        n_total++;
        if (bus.fsm_busy !== 1'b0 || bus.memory_read_en !== 1'b0)
            $display("FAIL miss_cycle_idle busy=%b rd=%b want 0/0", bus.fsm_busy, bus.memory_read_en);
        else n_pass++;
        for (int k = 0; k <= 8 + lat; k++) begin
            @(negedge clk);
            in_fill = (k < 8 + lat);
            beat = k - lat;
            bus.miss_detected = hold_miss && in_fill;
            bus.miss_address = 16'h4000;
            bus.memory_data_valid = in_fill && beat >= 0;
            bus.memory_data = 16'($urandom);
            #1;
            rd = (k < 8);
            wr = bus.memory_data_valid;
            exp = {in_fill, rd, rd ? 16'(base + 16'(2 * k)) : 16'd0, wr,
                   wr ? 3'(beat) : 3'd0, wr ? bus.memory_data : 16'd0,
                   wr && beat == 7, base};
            obs = observe(wr);
            n_total++;
            if (obs !== exp)
                $display("FAIL fill a=%h lat=%0d k=%0d got=%h want=%h", addr, lat, k, obs, exp);
            else n_pass++;
        end
        idle_inputs();
        last_base = base;
    endtask

    task automatic test_basic_fill();
        run_fill(16'h1236, 4, 1'b0);
    endtask

    task automatic test_latency_sweep();
        run_fill(16'h1236, 1, 1'b0);
        run_fill(16'h1236, 9, 1'b0);
    endtask

    task automatic test_miss_held();
        run_fill(16'h1236, 4, 1'b1);
        run_fill(16'h4000, 4, 1'b0);
    endtask

    task automatic test_idle_valid();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.memory_data_valid = 1'b1;
            bus.memory_data = 16'hBEEF;
            #1;
            n_total++;
            if ({bus.write_data_array, bus.write_tag_array, bus.fsm_busy, bus.fill_block_addr} !== {3'b000, last_base})
                $display("FAIL idle_valid wr=%b tag=%b busy=%b fba=%h want 0/0/0 fba=%h",
                         bus.write_data_array, bus.write_tag_array, bus.fsm_busy, bus.fill_block_addr, last_base);
            else n_pass++;
        end
        idle_inputs();
        run_fill(16'h0BAD, 2, 1'b0);
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clk);
        bus.miss_detected = 1'b1;
        bus.miss_address = 16'h1236;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            bus.miss_detected = 1'b0;
            rst = (k == 7);
            bus.memory_data_valid = (k >= 4 && k < 12);
            bus.memory_data = 16'($urandom);
            #1;
            if (k >= 8) begin
                n_total++;
                if ({bus.fsm_busy, bus.memory_read_en, bus.memory_address, bus.write_data_array,
                     bus.write_tag_array, bus.fill_block_addr} !== 35'd0)
                    $display("FAIL reset_mid k=%0d busy=%b rd=%b wr=%b tag=%b fba=%h want all 0", k,
                             bus.fsm_busy, bus.memory_read_en, bus.write_data_array,
                             bus.write_tag_array, bus.fill_block_addr);
                else n_pass++;
            end else if (k >= 4) begin
                n_total++;
                if (bus.write_tag_array !== 1'b0 || bus.write_data_array !== 1'b1)
                    $display("FAIL reset_mid_beat k=%0d wr=%b tag=%b want 1/0", k,
                             bus.write_data_array, bus.write_tag_array);
                else n_pass++;
            end
        end
        rst = 1'b0;
        idle_inputs();
        last_base = 16'h0000;
        run_fill(16'h2A5C, 3, 1'b0);
    endtask

    task automatic test_random_fills();
        for (int i = 0; i < 5; i++)
            run_fill(16'($urandom), int'($urandom_range(1, 9)), 1'($urandom_range(0, 1)));
        run_fill(16'hFFF7, 5, 1'b0);
    endtask

`ifdef FILL_PERF_CNT_EN
    task automatic test_perf();
        test_reset();
        n_total++;
        if (miss_count !== 16'd0 || fill_cycles !== 16'd0)
            $display("FAIL perf_reset miss_count=%0d fill_cycles=%0d want 0/0", miss_count, fill_cycles);
        else n_pass++;
        for (int i = 0; i < 3; i++) run_fill(16'h1236, 4, 1'b0);
        #1;
        n_total++;
        if (miss_count !== 16'd3 || fill_cycles !== 16'd36)
            $display("FAIL perf_counts miss_count=%0d fill_cycles=%0d want 3/36", miss_count, fill_cycles);
        else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        last_base = '0;
        test_reset();
        test_basic_fill();
        test_latency_sweep();
        test_miss_held();
        test_idle_valid();
        test_reset_mid_fill();
        test_random_fills();
`ifdef FILL_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout reached with %0d/%0d done", n_pass, n_total);
        $fatal(1);
    end
endmodule
